// File: rtl/button_bank.sv
// Multi-channel button conditioner: per-channel synchroniser, debounce FSM, long-press and release detection.
// Optional auto-repeat in the LONG state is enabled by defining BUTTON_BANK_REPEAT_EN.
module button_bank #(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 1000,
  parameter int REPEAT_CYC   = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_button,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int MAX_CYC = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYC - 1);
`ifdef BUTTON_BANK_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DB_DN = 3'd1,
    ST_HELD  = 3'd2,
    ST_LONG  = 3'd3,
    ST_DB_UP = 3'd4
  } state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          active;
    state_e        state_q, state_d;
    logic [CW-1:0] db_q, db_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    // Events are captured one cycle, then presented on the outputs the next,
    // so the pulses line up with o_level tracking the registered state.
    logic          press_pend_q, press_pend_d;
    logic          release_pend_q, release_pend_d;
    logic          long_pend_q, long_pend_d;
    logic          level_q, level_d;
    logic          press_q, release_q, long_q;
`ifdef BUTTON_BANK_REPEAT_EN
    logic [CW-1:0] rep_q, rep_d;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync1_q <= ACTIVE_LOW;
        sync2_q <= ACTIVE_LOW;
      end else begin
        sync1_q <= i_button[g];
        sync2_q <= sync1_q;
      end
    end

    assign active = sync2_q ^ ACTIVE_LOW;

    always_comb begin
      state_d        = state_q;
      db_d           = db_q;
      hold_d         = hold_q;
      long_done_d    = long_done_q;
      press_pend_d   = 1'b0;
      release_pend_d = 1'b0;
      long_pend_d    = 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
      rep_d          = rep_q;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (active) begin
            state_d = ST_DB_DN;
            db_d    = '0;
          end
        end
        ST_DB_DN: begin
          if (!active) begin
            state_d = ST_IDLE;
          end else if (db_q == DB_LAST) begin
            state_d      = ST_HELD;
            hold_d       = '0;
            long_done_d  = 1'b0;
            press_pend_d = 1'b1;
          end else begin
            db_d = sat_inc(db_q);
          end
        end
        ST_HELD: begin
          if (!active) begin
            state_d = ST_DB_UP;
            db_d    = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d     = ST_LONG;
            long_done_d = 1'b1;
            long_pend_d = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
            rep_d       = '0;
`endif
          end else begin
            hold_d = sat_inc(hold_q);
          end
        end
        ST_LONG: begin
          if (!active) begin
            state_d = ST_DB_UP;
            db_d    = '0;
          end
`ifdef BUTTON_BANK_REPEAT_EN
          else if (rep_q == REP_LAST) begin
            rep_d        = '0;
            press_pend_d = 1'b1;
          end else begin
            rep_d = sat_inc(rep_q);
          end
`endif
        end
        ST_DB_UP: begin
          // A bounce back to pressed resumes where the press left off.
          if (active) begin
            state_d = long_done_q ? ST_LONG : ST_HELD;
          end else if (db_q == DB_LAST) begin
            state_d        = ST_IDLE;
            release_pend_d = 1'b1;
          end else begin
            db_d = sat_inc(db_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      level_d = (state_q == ST_HELD) || (state_q == ST_LONG) || (state_q == ST_DB_UP);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q        <= ST_IDLE;
        db_q           <= '0;
        hold_q         <= '0;
        long_done_q    <= 1'b0;
        press_pend_q   <= 1'b0;
        release_pend_q <= 1'b0;
        long_pend_q    <= 1'b0;
        level_q        <= 1'b0;
        press_q        <= 1'b0;
        release_q      <= 1'b0;
        long_q         <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
        rep_q          <= '0;
`endif
      end else begin
        state_q        <= state_d;
        db_q           <= db_d;
        hold_q         <= hold_d;
        long_done_q    <= long_done_d;
        press_pend_q   <= press_pend_d;
        release_pend_q <= release_pend_d;
        long_pend_q    <= long_pend_d;
        level_q        <= level_d;
        press_q        <= press_pend_q;
        release_q      <= release_pend_q;
        long_q         <= long_pend_q;
`ifdef BUTTON_BANK_REPEAT_EN
        rep_q          <= rep_d;
`endif
      end
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
  end

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank: press latency, bounce, long press, glitch, release, reset mid-press.
module tb_button_bank;
  localparam int N_CH = 2;
  localparam int DB   = 4;
  localparam int LC   = 10;
  localparam int RC   = 5;
`ifdef BUTTON_BANK_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] o_level, o_press, o_release, o_long;

  int n_checks = 0;
  int n_errors = 0;

  button_bank #(
    .N_CH(N_CH), .DEBOUNCE_CYC(DB), .LONG_CYC(LC), .REPEAT_CYC(RC), .ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_button(button),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_long(o_long)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rep_at(input int k, input int first, input int last);
    return REP && (k >= first) && (k <= last) && (((k - first) % RC) == 0);
  endfunction

  initial begin
    rst    = 1'b1;
    button = '1;
    repeat (3) tick();
    check("reset level",   32'(o_level),   32'd0);
    check("reset press",   32'(o_press),   32'd0);
    check("reset release", 32'(o_release), 32'd0);
    check("reset long",    32'(o_long),    32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // ch0 pressed and held; press at 7, long at 17, repeats from 22 when enabled
    button[0] = 1'b0;
    for (int k = 0; k <= 47; k++) begin
      tick();
      check($sformatf("A press0 k=%0d", k),   32'(o_press[0]),   32'(k == 7 || rep_at(k, 22, 47)));
      check($sformatf("A level0 k=%0d", k),   32'(o_level[0]),   32'(k >= 7));
      check($sformatf("A long0 k=%0d", k),    32'(o_long[0]),    32'(k == 17));
      check($sformatf("A release0 k=%0d", k), 32'(o_release[0]), 32'd0);
      check($sformatf("A ch1 k=%0d", k),
            32'({o_level[1], o_press[1], o_release[1], o_long[1]}), 32'd0);
    end

    // two-cycle release glitch while LONG: pin high sampled at 48 and 49
    for (int k = 48; k <= 60; k++) begin
      button[0] = (k == 48 || k == 49);
      tick();
      check($sformatf("G press0 k=%0d", k),   32'(o_press[0]),   32'(REP && (k == 55 || k == 60)));
      check($sformatf("G level0 k=%0d", k),   32'(o_level[0]),   32'd1);
      check($sformatf("G long0 k=%0d", k),    32'(o_long[0]),    32'd0);
      check($sformatf("G release0 k=%0d", k), 32'(o_release[0]), 32'd0);
    end

    // real release: pin high first sampled at 61, release at 68
    button[0] = 1'b1;
    for (int k = 61; k <= 72; k++) begin
      tick();
      check($sformatf("R release0 k=%0d", k), 32'(o_release[0]), 32'(k == 68));
      check($sformatf("R level0 k=%0d", k),   32'(o_level[0]),   32'(k < 68));
      check($sformatf("R press0 k=%0d", k),   32'(o_press[0]),   32'd0);
      check($sformatf("R long0 k=%0d", k),    32'(o_long[0]),    32'd0);
    end
    repeat (4) tick();

    // ch1 bounce: low at 0..2, high at 3, low from 4; press counted from 4
    for (int k = 0; k <= 15; k++) begin
      button[1] = (k == 3);
      tick();
      check($sformatf("B press1 k=%0d", k),   32'(o_press[1]),   32'(k == 11));
      check($sformatf("B level1 k=%0d", k),   32'(o_level[1]),   32'(k >= 11));
      check($sformatf("B release1 k=%0d", k), 32'(o_release[1]), 32'd0);
      check($sformatf("B ch0 k=%0d", k),
            32'({o_level[0], o_press[0], o_release[0], o_long[0]}), 32'd0);
    end

    // reset pulse while ch1 HELD: outputs drop without a clock edge
    rst = 1'b1;
    #1;
    check("X async level",   32'(o_level),   32'd0);
    check("X async press",   32'(o_press),   32'd0);
    check("X async release", 32'(o_release), 32'd0);
    check("X async long",    32'(o_long),    32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      tick();
      check($sformatf("X press1 k=%0d", k),   32'(o_press[1]),   32'(k == 7));
      check($sformatf("X level1 k=%0d", k),   32'(o_level[1]),   32'(k >= 7));
      check($sformatf("X release1 k=%0d", k), 32'(o_release[1]), 32'd0);
      check($sformatf("X long1 k=%0d", k),    32'(o_long[1]),    32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
